cla_serial_ctrl: RTL
====================

# cla_serial_ctrl

Multi-cycle 32-bit add/subtract sequencer for the ALU32 area. It owns one 4-bit carry look-ahead slice (generate/propagate, c1..c3, co) and drives it over eight consecutive cycles, least-significant nibble first, through a registered ripple carry. It is the low-area alternative to the fully parallel 32-bit adder. A start/busy/done handshake to the ALU control logic sequences each operation.

## Interface
- DATA_W, 32, operand/result width; must be a multiple of SLICE_W
- SLICE_W, 4, width of the look-ahead slice processed per cycle; NSLICE = DATA_W/SLICE_W (8 at defaults)
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only when ready (state IDLE or DONE)
- op_sub  in  1  0 = a+b, 1 = a-b; sampled with start
- a  in  DATA_W  operand A; sampled with start
- b  in  DATA_W  operand B; sampled with start
- busy  out  1  high while state RUN
- done  out  1  one-cycle pulse, high while state DONE
- result  out  DATA_W  sum/difference register
- co  out  1  carry out of MSB (for subtract, 1 = no borrow)
- ov  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE. Slice counter idx, 0..NSLICE-1.
- IDLE/DONE with start=1:
  - latch a_r=a and b_r = op_sub ? ~b : b
  - carry register cr = op_sub
  - idx = 0, go to RUN
  - result, co and ov are left unchanged until slices overwrite them.
- IDLE/DONE with start=0: hold. DONE always leaves to IDLE or RUN after one cycle.
- RUN, each cycle:
  - slice inputs: a_r[idx*SLICE_W +: SLICE_W], b_r[same], cr
  - slice sum bit i = a^b^c_i, with c_0 = cr and c1..c3 from the look-ahead equations (g = a&b, p = a|b)
  - write the slice sum into the same field of result; cr <= slice co; idx++
- Last slice (idx = NSLICE-1):
  - co <= slice co
  - ov <= carry into bit DATA_W-1 XOR slice co
  - go to DONE
- start during RUN is ignored: no latch, no queueing.
- result holds its final value from DONE until the next accepted start. Partial results are visible during RUN and are not valid.
- Width rules: no sign extension. The carry out of the MSB is dropped from result and reported only on co.

## Timing
- Reset (reset_n=0 at a rising edge): state IDLE, idx=0, cr=0, result=0, co=0, ov=0, busy=0, done=0. Reset wins over every other event, including mid-RUN; the operation is abandoned with no done pulse.
- Start accepted at edge E0. busy=1 from after E0 through E(NSLICE-1), i.e. 8 cycles.
- At E(NSLICE), i.e. E8: final slice is written, busy=0, done=1 for exactly one cycle. Latency from start edge to done is NSLICE+1 = 9 edges.
- Back-to-back: start=1 while done=1 is accepted at that edge. busy=1 the next cycle and done drops; throughput is one operation per NSLICE+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Add wrap: a=0xFFFFFFFF, b=0x00000001, op_sub=0.
  - done exactly 9 cycles after start
  - result=0x00000000, co=1, ov=0
  - busy high 8 cycles
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, add.
  - result=0x80000000, co=0, ov=1
- Subtract:
  - 7-5 → result=0x00000002, co=1, ov=0
  - 5-7 → result=0xFFFFFFFE, co=0, ov=0
  - 0x80000000-1 → result=0x7FFFFFFF, ov=1
- Start during RUN: start at cycle 3 of a 0x12345678+0x11111111 operation with different operands.
  - ignored; result=0x23456789
  - single done pulse at cycle 9
- Reset mid-op: reset_n low for one edge at cycle 4 of RUN.
  - next cycle busy=0, result=0, co=0, ov=0
  - no done pulse; a new start afterwards completes normally
- Back-to-back: second start (0x00000010-0x00000001) asserted in the done cycle of the first.
  - accepted; busy next cycle
  - second done exactly 9 edges later; result=0x0000000F, co=1

Source files
------------

// File: rtl/cla_serial_ctrl.sv
// cla_serial_ctrl: multi-cycle add/subtract sequencer. One SLICE_W-bit carry
// look-ahead slice is reused NSLICE times, least-significant slice first, with
// the carry between slices held in a register. start/busy/done handshake.
module cla_serial_ctrl #(
   parameter int DATA_W  = 32,
   parameter int SLICE_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              op_sub,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              co,
   output logic              ov
);

   localparam int NSLICE = DATA_W / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   a_r;
   logic [DATA_W-1:0]   b_r;
   logic                cr;
   logic                accept;
   logic                last;
   int                  lsb;

   // Slice datapath signals
   logic [SLICE_W-1:0]  s_a;
   logic [SLICE_W-1:0]  s_b;
   logic [SLICE_W-1:0]  g;
   logic [SLICE_W-1:0]  p;
   logic [SLICE_W:0]    gc;      // {g, carry-in}: gc[0] = cr, gc[j+1] = g[j]
   logic [SLICE_W:0]    c;       // c[0] = carry-in, c[SLICE_W] = slice carry-out
   logic [SLICE_W-1:0]  sum;
   logic                term;

   // Select the active slice of the latched operands
   always_comb begin
      lsb = int'(idx) * SLICE_W;
      s_a = a_r[lsb +: SLICE_W];
      s_b = b_r[lsb +: SLICE_W];
   end

   // Flattened look-ahead: every carry is a sum of products of g/p and the
   // slice carry-in, so no carry ripples through the slice.
   // NOTE: every variable written in a combinational block gets a value on
   // every path (defaults first); otherwise a latch is inferred.
   always_comb begin
      g    = s_a & s_b;
      p    = s_a | s_b;
      gc   = {g, cr};
      c    = '0;
      term = 1'b0;
      c[0] = cr;
      for (int i = 0; i < SLICE_W; i++) begin
         for (int j = 0; j <= i + 1; j++) begin
            term = gc[j];
            for (int k = j; k <= i; k++) begin
               term = term & p[k];
            end
            c[i+1] = c[i+1] | term;
         end
      end
      sum = s_a ^ s_b ^ c[SLICE_W-1:0];
   end

   // Next-state logic and start acceptance
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = (idx == IDX_W'(NSLICE - 1));
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else if (state == DONE) begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   // NOTE: clocked blocks use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Operand capture; inverting b here turns subtract into add with carry-in 1
   // NOTE: operand registers carry no reset; they are always loaded on an
   // accepted start before the slice ever reads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_r <= a;
         b_r <= op_sub ? ~b : b;
      end
   end

   // Slice sequencing: write one slice of result per RUN cycle, carry forward
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         idx    <= '0;
         cr     <= 1'b0;
         result <= '0;
         co     <= 1'b0;
         ov     <= 1'b0;
      end else if (accept) begin
         idx <= '0;
         cr  <= op_sub;
      end else if (state == RUN) begin
         result[lsb +: SLICE_W] <= sum;
         cr                     <= c[SLICE_W];
         idx                    <= idx + 1'b1;
         if (last) begin
            co <= c[SLICE_W];
            ov <= c[SLICE_W-1] ^ c[SLICE_W];
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
